// File: rtl/dmem_access_unit.sv
// Load/store sequencer between the MEM stage and the data-memory port.
// req_op / ld_op encoding: B=0 UB=1 H=2 UH=3 W=4 UW=5 D=6 NO=7.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wmask,
  input  logic        dmem_resp_valid,
  input  logic [63:0] dmem_rdata,
  output logic        dmem_resp_ready,
  output logic [63:0] ld_data,
  output logic [63:0] ld_addr,
  output logic [2:0]  ld_op,
  output logic        done,
  output logic        misalign,
  output logic        acc_err
);

  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_UB = 3'd1;
  localparam logic [2:0] MEM_H  = 3'd2;
  localparam logic [2:0] MEM_UH = 3'd3;
  localparam logic [2:0] MEM_W  = 3'd4;
  localparam logic [2:0] MEM_UW = 3'd5;
  localparam logic [2:0] MEM_D  = 3'd6;
  localparam logic [2:0] MEM_NO = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  function automatic logic [7:0] lane_mask(input logic [2:0] op, input logic [2:0] off);
    logic [7:0] m;
    case (op)
      MEM_B, MEM_UB: m = 8'h01 << off;
      MEM_H, MEM_UH: m = 8'h03 << off;
      MEM_W, MEM_UW: m = 8'h0F << off;
      MEM_D:         m = 8'hFF;
      default:       m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [2:0] off);
    logic mis;
    case (op)
      MEM_H, MEM_UH: mis = (off[0] != 1'b0);
      MEM_W, MEM_UW: mis = (off[1:0] != 2'b00);
      MEM_D:         mis = (off != 3'b000);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [63:0] addr_r;
  logic [2:0]  op_r;
  logic        we_r;
  logic [7:0]  mask_r;
  logic [63:0] wdata_r;
  logic [7:0]  cnt_r;
  logic [63:0] ld_data_r;
  logic [63:0] ld_addr_r;
  logic [2:0]  ld_op_r;
  logic        acc_err_r;

  logic        req_live_s;
  logic        mis_s;
  logic        accept_s;
  logic        handshake_s;
  logic        resp_take_s;
  logic        timeout_s;

  assign req_live_s  = (state_r == ST_IDLE) && req_valid && (req_op != MEM_NO);
  assign mis_s       = is_misaligned(req_op, req_addr[2:0]);
  assign accept_s    = req_live_s && !mis_s;
  assign handshake_s = (state_r == ST_REQ) && dmem_req_ready;
  // Responses only count once the request has been handed over.
  assign resp_take_s = (state_r == ST_WAIT) && dmem_resp_valid;
  assign timeout_s   = (state_r == ST_WAIT) && !dmem_resp_valid && (cnt_r == TIMEOUT_LIM - 8'd1);

  // Next-state selection for the access sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_REQ;
        else          state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (dmem_req_ready) state_nxt_s = ST_WAIT;
        else                state_nxt_s = ST_REQ;
      end
      ST_WAIT: begin
        if (dmem_resp_valid) state_nxt_s = ST_DONE;
        else if (timeout_s)  state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_WAIT;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and WAIT-cycle counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (handshake_s)                              cnt_r <= 8'd0;
      else if (state_r == ST_WAIT && !dmem_resp_valid) cnt_r <= cnt_r + 8'd1;
      else                                          cnt_r <= cnt_r;
    end
  end

  // Capture of the accepted request; loads carry no mask and no data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_r  <= 64'd0;
      op_r    <= MEM_NO;
      we_r    <= 1'b0;
      mask_r  <= 8'h00;
      wdata_r <= 64'd0;
    end else if (accept_s) begin
      addr_r  <= req_addr;
      op_r    <= req_op;
      we_r    <= req_we;
      mask_r  <= req_we ? lane_mask(req_op, req_addr[2:0]) : 8'h00;
      wdata_r <= req_we ? (req_wdata << {req_addr[2:0], 3'b000}) : 64'd0;
    end else begin
      addr_r  <= addr_r;
      op_r    <= op_r;
      we_r    <= we_r;
      mask_r  <= mask_r;
      wdata_r <= wdata_r;
    end
  end

  // Completion results for the load-truncation stage and the timeout pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_data_r <= 64'd0;
      ld_addr_r <= 64'd0;
      ld_op_r   <= MEM_NO;
      acc_err_r <= 1'b0;
    end else if (resp_take_s) begin
      ld_data_r <= we_r ? ld_data_r : dmem_rdata;
      ld_addr_r <= addr_r;
      ld_op_r   <= op_r;
      acc_err_r <= 1'b0;
    end else if (timeout_s) begin
      ld_data_r <= 64'd0;
      ld_addr_r <= ld_addr_r;
      ld_op_r   <= ld_op_r;
      acc_err_r <= 1'b1;
    end else begin
      ld_data_r <= ld_data_r;
      ld_addr_r <= ld_addr_r;
      ld_op_r   <= ld_op_r;
      acc_err_r <= 1'b0;
    end
  end

  assign stall           = accept_s || (state_r == ST_REQ) || (state_r == ST_WAIT);
  assign misalign        = req_live_s && mis_s;
  assign dmem_req_valid  = (state_r == ST_REQ);
  assign dmem_we         = we_r;
  assign dmem_addr       = {addr_r[63:3], 3'b000};
  assign dmem_wdata      = wdata_r;
  assign dmem_wmask      = mask_r;
  assign dmem_resp_ready = (state_r == ST_WAIT);
  assign ld_data         = ld_data_r;
  assign ld_addr         = ld_addr_r;
  assign ld_op           = ld_op_r;
  assign done            = (state_r == ST_DONE);
  assign acc_err         = acc_err_r;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed plan cases, then random
// accesses checked against a transaction-level reference model.
module tb_dmem_access_unit;

  localparam int TO = 4;

  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_UB = 3'd1;
  localparam logic [2:0] MEM_H  = 3'd2;
  localparam logic [2:0] MEM_UH = 3'd3;
  localparam logic [2:0] MEM_W  = 3'd4;
  localparam logic [2:0] MEM_UW = 3'd5;
  localparam logic [2:0] MEM_D  = 3'd6;
  localparam logic [2:0] MEM_NO = 3'd7;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = MEM_NO;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_resp_valid = 1'b0;
  logic [63:0] dmem_rdata = 64'd0;
  logic        dmem_resp_ready;
  logic [63:0] ld_data;
  logic [63:0] ld_addr;
  logic [2:0]  ld_op;
  logic        done;
  logic        misalign;
  logic        acc_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_ld_data = 64'd0;
  logic [63:0] m_ld_addr = 64'd0;
  logic [2:0]  m_ld_op   = MEM_NO;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .dmem_resp_ready(dmem_resp_ready),
    .ld_data(ld_data), .ld_addr(ld_addr), .ld_op(ld_op),
    .done(done), .misalign(misalign), .acc_err(acc_err)
  );

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for MEM_NO.
  function automatic int op_bytes(input logic [2:0] op);
    case (op)
      MEM_B, MEM_UB: return 1;
      MEM_H, MEM_UH: return 2;
      MEM_W, MEM_UW: return 4;
      MEM_D:         return 8;
      default:       return 0;
    endcase
  endfunction

  function automatic logic m_misalign(input logic [2:0] op, input logic [63:0] addr);
    int n = op_bytes(op);
    if (n <= 1) return 1'b0;
    return (addr % 64'(n)) != 64'd0;
  endfunction

  function automatic logic [7:0] m_mask(input logic [2:0] op, input logic [63:0] addr);
    int n = op_bytes(op);
    int off = int'(addr % 64'd8);
    int m;
    if (n == 0) return 8'h00;
    m = ((1 << n) - 1) << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [63:0] addr);
    logic [127:0] w;
    w = {64'd0, wd} * (128'd1 << (8 * (addr % 64'd8)));
    return w[63:0];
  endfunction

  task automatic noise();
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_op    = 3'($urandom_range(0, 7));
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
  endtask

  // One complete access; entered and left just after a rising edge with the unit idle.
  task automatic access(input logic we, input logic [2:0] op, input logic [63:0] addr,
                        input logic [63:0] wd, input int rdy_dly, input int rsp_dly,
                        input logic [63:0] rd, input logic early_rsp);
    logic ignored;
    logic mis;
    logic [7:0] exp_mk;
    logic [63:0] exp_wd;
    ignored = (op_bytes(op) == 0);
    mis     = m_misalign(op, addr);
    exp_mk  = we ? m_mask(op, addr) : 8'h00;
    exp_wd  = we ? m_wdata(wd, addr) : 64'd0;
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    chk1("misalign", misalign, !ignored && mis);
    chk1("stall_accept", stall, !ignored && !mis);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ignored || mis) begin
      @(negedge clk);
      chk1("no_req_valid", dmem_req_valid, 1'b0);
      chk1("no_done", done, 1'b0);
      chk1("idle_stall", stall, 1'b0);
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      if (i > 0) noise();
      dmem_req_ready  = (i == rdy_dly);
      dmem_resp_valid = early_rsp && (i == rdy_dly);
      dmem_rdata      = ~rd;
      @(negedge clk);
      chk1("req_valid", dmem_req_valid, 1'b1);
      chk1("req_stall", stall, 1'b1);
      chk1("req_we", dmem_we, we);
      chk64("req_addr", dmem_addr, addr - (addr % 64'd8));
      chk8("req_wmask", dmem_wmask, exp_mk);
      chk64("req_wdata", dmem_wdata, exp_wd);
      chk1("req_resp_ready", dmem_resp_ready, 1'b0);
      @(posedge clk); #1;
    end
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    if (rsp_dly >= TO) begin
      for (int i = 0; i < TO; i++) begin
        noise();
        dmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk1("wait_resp_ready", dmem_resp_ready, 1'b1);
        chk1("wait_stall", stall, 1'b1);
        chk1("wait_acc_err", acc_err, 1'b0);
        @(posedge clk); #1;
      end
      req_valid = 1'b0;
      m_ld_data = 64'd0;
      @(negedge clk);
      chk1("acc_err_pulse", acc_err, 1'b1);
      chk1("timeout_no_done", done, 1'b0);
      chk1("timeout_stall", stall, 1'b0);
      chk1("timeout_resp_ready", dmem_resp_ready, 1'b0);
      chk64("timeout_ld_data", ld_data, m_ld_data);
    end else begin
      for (int i = 0; i < rsp_dly; i++) begin
        noise();
        dmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk1("wait_resp_ready", dmem_resp_ready, 1'b1);
        chk1("wait_stall", stall, 1'b1);
        chk1("wait_done", done, 1'b0);
        @(posedge clk); #1;
      end
      noise();
      dmem_resp_valid = 1'b1;
      dmem_rdata = rd;
      @(negedge clk);
      chk1("resp_cycle_ready", dmem_resp_ready, 1'b1);
      @(posedge clk); #1;
      dmem_resp_valid = 1'b0;
      req_valid = 1'b0;
      if (!we) m_ld_data = rd;
      m_ld_addr = addr;
      m_ld_op   = op;
      @(negedge clk);
      chk1("done_pulse", done, 1'b1);
      chk1("done_stall", stall, 1'b0);
      chk64("ld_data", ld_data, m_ld_data);
      chk64("ld_addr", ld_addr, m_ld_addr);
      chk8("ld_op", 8'(ld_op), 8'(m_ld_op));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk1("after_done", done, 1'b0);
    chk1("after_acc_err", acc_err, 1'b0);
    chk1("after_stall", stall, 1'b0);
    chk1("after_req_valid", dmem_req_valid, 1'b0);
    chk64("after_ld_data", ld_data, m_ld_data);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_we;
    logic [2:0]  r_op;
    logic [63:0] r_addr;
    int          n;

    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_req_valid", dmem_req_valid, 1'b0);
    chk1("rst_resp_ready", dmem_resp_ready, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_acc_err", acc_err, 1'b0);
    chk64("rst_ld_data", ld_data, 64'd0);
    chk8("rst_ld_op", 8'(ld_op), 8'(MEM_NO));
    chk8("rst_wmask", dmem_wmask, 8'h00);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Byte store, word load, misaligned half, ignored MEM_NO
    access(1'b1, MEM_B, 64'h1003, 64'hAB, 0, 0, 64'd0, 1'b0);
    chk64("byte_store_ld_addr", ld_addr, 64'h1003);
    access(1'b0, MEM_W, 64'h2004, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3, 64'h8000000112345678, 1'b0);
    chk64("word_load_data", ld_data, 64'h8000000112345678);
    access(1'b0, MEM_H, 64'h3001, 64'd0, 0, 0, 64'd0, 1'b0);
    access(1'b1, MEM_NO, 64'h3100, 64'h55, 0, 0, 64'd0, 1'b0);

    // Backpressure, store keeps previous ld_data, timeout, early response ignored
    access(1'b1, MEM_D, 64'h4000, 64'h0123_4567_89AB_CDEF, 5, 0, 64'hDEAD, 1'b0);
    access(1'b0, MEM_W, 64'h6008, 64'd0, 0, TO, 64'd0, 1'b0);
    access(1'b0, MEM_UH, 64'h7002, 64'd0, 1, 2, 64'hCAFE_F00D_1234_5678, 1'b1);
    access(1'b1, MEM_UW, 64'h7104, 64'hFFFF_FFFF_8765_4321, 0, 1, 64'h1111, 1'b0);

    // Reset during WAIT, then a late response that must be ignored
    req_valid = 1'b1; req_we = 1'b0; req_op = MEM_D; req_addr = 64'h5000;
    @(posedge clk); #1;
    req_valid = 1'b0; dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    @(negedge clk);
    chk1("pre_rst_resp_ready", dmem_resp_ready, 1'b1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #2;
    chk1("midrst_stall", stall, 1'b0);
    chk1("midrst_resp_ready", dmem_resp_ready, 1'b0);
    chk1("midrst_req_valid", dmem_req_valid, 1'b0);
    chk64("midrst_ld_data", ld_data, 64'd0);
    chk64("midrst_ld_addr", ld_addr, 64'd0);
    chk8("midrst_ld_op", 8'(ld_op), 8'(MEM_NO));
    chk64("midrst_dmem_addr", dmem_addr, 64'd0);
    m_ld_data = 64'd0; m_ld_addr = 64'd0; m_ld_op = MEM_NO;
    @(posedge clk); #1;
    rstn = 1'b1;
    dmem_resp_valid = 1'b1; dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("late_resp_done", done, 1'b0);
      chk64("late_resp_ld_data", ld_data, m_ld_data);
      @(posedge clk); #1;
    end
    dmem_resp_valid = 1'b0;

    // Random accesses
    for (int k = 0; k < 60; k++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_op   = 3'($urandom_range(0, 7));
      r_addr = {$urandom, $urandom};
      n      = op_bytes(r_op);
      if ($urandom_range(0, 3) != 0 && n > 0) r_addr = r_addr - (r_addr % 64'(n));
      access(r_we, r_op, r_addr, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
             {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
